regfile_write_sequencer: RTL and testbench



---
 rtl/regfile_write_sequencer.sv | 111 +++++++++++
 tb/tb_regfile_write_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// Write-side front end for the register file: multiplexes a hardware clear
// sweep and a 2-deep buffered client write channel onto the single write port.
module regfile_write_sequencer #(
  parameter int                    addr_width    = 1,
  parameter int                    data_width    = 1,
  parameter int                    lo            = 0,
  parameter int                    hi            = 1,
  parameter logic [data_width-1:0] init_val      = '0,
  parameter bit                    init_on_reset = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [addr_width-1:0] WR_ADDR,
  input  logic [data_width-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  WR_RDY,
  input  logic                  CLR,
  output logic                  BUSY,
  output logic                  ERR_OOR,
  output logic [addr_width-1:0] RF_ADDR_IN,
  output logic [data_width-1:0] RF_D_IN,
  output logic                  RF_WE
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam state_t                reset_state = init_on_reset ? CLEAR : IDLE;
  localparam logic [addr_width-1:0] lo_a        = addr_width'(lo);
  localparam logic [addr_width-1:0] hi_a        = addr_width'(hi);
  localparam logic [addr_width:0]   span        = {1'b0, hi_a - lo_a};

  state_t                state, state_next;
  logic [addr_width-1:0] cnt;

  logic [addr_width-1:0] fifo_addr [2];
  logic [data_width-1:0] fifo_data [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            count;

  logic [addr_width-1:0] rel;
  logic                  in_range, accept, push, pop;

  // Offset from lo wraps past span when the address is below lo, so a single
  // unsigned compare covers both bounds.
  assign rel      = WR_ADDR - lo_a;
  assign in_range = ({1'b0, rel} <= span);

  assign WR_RDY = (count != 2'd2);
  assign BUSY   = (state == CLEAR);
  assign accept = WR_EN && WR_RDY;
  assign push   = accept && in_range;
  assign pop    = (state == IDLE) && !CLR && (count != 2'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= reset_state;
    else        state <= state_next;
  end

  // NOTE: default assigned first so every path drives state_next; no latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (CLR)         state_next = CLEAR;
      CLEAR: if (cnt == hi_a) state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt        <= lo_a;
      RF_WE      <= 1'b0;
      RF_ADDR_IN <= '0;
      RF_D_IN    <= '0;
      ERR_OOR    <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (state == CLEAR) begin
        RF_WE      <= 1'b1;
        RF_ADDR_IN <= cnt;
        RF_D_IN    <= init_val;
        cnt        <= (cnt == hi_a) ? lo_a : cnt + addr_width'(1);
      end else if (pop) begin
        RF_WE      <= 1'b1;
        RF_ADDR_IN <= fifo_addr[rd_ptr];
        RF_D_IN    <= fifo_data[rd_ptr];
        rd_ptr     <= ~rd_ptr;
      end else begin
        RF_WE <= 1'b0;
      end

      ERR_OOR <= accept && !in_range;

      if (push) wr_ptr <= ~wr_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  // NOTE: storage is deliberately not reset; count alone marks entries valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= WR_ADDR;
      fifo_data[wr_ptr] <= WR_DATA;
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Self-checking bench: a directed vector table on a lo=2..hi=5 instance, hand
// sequences for sweep/reset corners, and a queue-based model under random traffic.
module tb_regfile_write_sequencer;

  localparam int MLO = 0;
  localparam int MHI = 7;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_en, wr_rdy, clr, busy, err_oor, rf_we;
  logic [3:0] rf_addr;
  logic [7:0] rf_data;

  logic [2:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_wr_en, r_wr_rdy, r_clr, r_busy, r_err_oor, r_rf_we;
  logic [2:0] r_rf_addr;
  logic [7:0] r_rf_data;

  int n_vec = 0;
  int n_err = 0;

  bit          collect = 1'b0;
  logic [11:0] mon_q[$];

  always #5 clk = ~clk;

  regfile_write_sequencer #(
    .addr_width(4), .data_width(8), .lo(0), .hi(7),
    .init_val(8'hA5), .init_on_reset(1'b1)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .WR_EN(wr_en), .WR_RDY(wr_rdy), .CLR(clr), .BUSY(busy), .ERR_OOR(err_oor),
    .RF_ADDR_IN(rf_addr), .RF_D_IN(rf_data), .RF_WE(rf_we)
  );

  regfile_write_sequencer #(
    .addr_width(3), .data_width(8), .lo(2), .hi(5),
    .init_val(8'h3C), .init_on_reset(1'b0)
  ) dut_r (
    .CLK(clk), .RST_N(rst_n), .WR_ADDR(r_wr_addr), .WR_DATA(r_wr_data),
    .WR_EN(r_wr_en), .WR_RDY(r_wr_rdy), .CLR(r_clr), .BUSY(r_busy), .ERR_OOR(r_err_oor),
    .RF_ADDR_IN(r_rf_addr), .RF_D_IN(r_rf_data), .RF_WE(r_rf_we)
  );

  always @(negedge clk) if (collect && rf_we) mon_q.push_back({rf_addr, rf_data});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    int k = 0;
    while (!wr_rdy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("write_rdy_wait", wr_rdy, 1);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_sweep(input string tag);
    for (int i = MLO; i <= MHI; i++) begin
      @(negedge clk);
      check({tag, "_we"},   rf_we,   1);
      check({tag, "_addr"}, rf_addr, i);
      check({tag, "_data"}, rf_data, 8'hA5);
      check({tag, "_busy"}, busy,    (i < MHI) ? 1 : 0);
    end
    @(negedge clk);
    check({tag, "_we_after"}, rf_we, 0);
  endtask

  typedef struct packed {
    logic       en;
    logic [2:0] addr;
    logic [7:0] data;
    logic       clr;
    logic       rdy;
    logic       busy;
    logic       we;
    logic [2:0] a;
    logic [7:0] d;
    logic       err;
  } vec_t;

  vec_t tbl[14];

  // Behavioural model state for the random phase.
  bit          m_busy;
  int          m_next;
  logic [11:0] m_q[$];
  logic        e_we, e_err;
  logic [3:0]  e_addr;
  logic [7:0]  e_data;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //             en    addr  data   clr   | rdy   busy  we    a     d      err
    tbl[0]  = '{1'b1, 3'd7, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[1]  = '{1'b1, 3'd1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 3'd3, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 8'h33, 1'b0};
    tbl[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'h33, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 8'h33, 1'b0};
    tbl[6]  = '{1'b1, 3'd2, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'h3C, 1'b0};
    tbl[7]  = '{1'b1, 3'd5, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h3C, 1'b0};
    tbl[8]  = '{1'b1, 3'd4, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 8'h3C, 1'b0};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h3C, 1'b0};
    tbl[10] = '{1'b1, 3'd3, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'h22, 1'b0};
    tbl[11] = '{1'b1, 3'd4, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h55, 1'b0};
    tbl[12] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 8'h44, 1'b0};
    tbl[13] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 8'h44, 1'b0};

    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    r_wr_en = 1'b0; r_wr_addr = '0; r_wr_data = '0; r_clr = 1'b0;

    // Reset values, then the automatic sweep after release.
    repeat (2) @(negedge clk);
    check("rst_we", rf_we, 0);
    check("rst_addr", rf_addr, 0);
    check("rst_data", rf_data, 0);
    check("rst_err", err_oor, 0);
    check("rst_busy", busy, 1);
    check("rst_rdy", wr_rdy, 1);
    check("rst_r_busy", r_busy, 0);
    check("rst_r_we", r_rf_we, 0);
    rst_n = 1'b1;
    check_sweep("init_sweep");

    // Directed vector table on the lo=2..hi=5 instance.
    for (int i = 0; i < 14; i++) begin
      r_wr_en = tbl[i].en; r_wr_addr = tbl[i].addr; r_wr_data = tbl[i].data; r_clr = tbl[i].clr;
      @(negedge clk);
      check($sformatf("tbl%0d_rdy", i),  r_wr_rdy,  tbl[i].rdy);
      check($sformatf("tbl%0d_busy", i), r_busy,    tbl[i].busy);
      check($sformatf("tbl%0d_we", i),   r_rf_we,   tbl[i].we);
      check($sformatf("tbl%0d_addr", i), r_rf_addr, tbl[i].a);
      check($sformatf("tbl%0d_data", i), r_rf_data, tbl[i].d);
      check($sformatf("tbl%0d_err", i),  r_err_oor, tbl[i].err);
    end
    r_wr_en = 1'b0; r_clr = 1'b0;

    // Single write: RF_WE rises on the edge after acceptance.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    check("single_we_accept_edge", rf_we, 0);
    @(negedge clk);
    check("single_we", rf_we, 1);
    check("single_addr", rf_addr, 3);
    check("single_data", rf_data, 8'h11);
    @(negedge clk);
    check("single_we_drop", rf_we, 0);

    // Six back-to-back writes stream through at one per cycle.
    for (int i = 1; i <= 6; i++) begin
      check("b2b_rdy", wr_rdy, 1);
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(8'h30 + i);
      @(negedge clk);
      check("b2b_we", rf_we, (i == 1) ? 0 : 1);
      if (i > 1) check("b2b_addr", rf_addr, i - 1);
    end
    wr_en = 1'b0;
    @(negedge clk);
    check("b2b_we_last", rf_we, 1);
    check("b2b_addr_last", rf_addr, 6);
    check("b2b_data_last", rf_data, 8'h36);
    @(negedge clk);
    check("b2b_we_end", rf_we, 0);

    // Clear sweep with client writes offered during it.
    mon_q.delete();
    collect = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_busy", busy, 1);
    do_write(4'd2, 8'h22);
    do_write(4'd4, 8'h44);
    check("clr_rdy_full", wr_rdy, 0);
    check("clr_busy_full", busy, 1);
    do_write(4'd6, 8'h66);
    repeat (4) @(negedge clk);
    collect = 1'b0;
    check("clr_nwrites", mon_q.size(), 11);
    if (mon_q.size() == 11) begin
      for (int i = 0; i < 8; i++) check("clr_sweep_entry", mon_q[i], {4'(i), 8'hA5});
      check("clr_client0", mon_q[8],  {4'd2, 8'h22});
      check("clr_client1", mon_q[9],  {4'd4, 8'h44});
      check("clr_client2", mon_q[10], {4'd6, 8'h66});
    end

    // Reset mid-sweep with two writes buffered.
    begin
      bit found = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hE1;
      @(negedge clk);
      wr_addr = 4'd2; wr_data = 8'hE2;
      @(negedge clk);
      wr_en = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
        if (rf_we && rf_addr == 4'd4) found = 1'b1;
        else @(negedge clk);
      end
      check("midrst_reached_addr4", found, 1);
      check("midrst_fifo_full", wr_rdy, 0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_we", rf_we, 0);
      check("midrst_addr", rf_addr, 0);
      check("midrst_data", rf_data, 0);
      check("midrst_err", err_oor, 0);
      check("midrst_rdy", wr_rdy, 1);
      check("midrst_busy", busy, 1);
      @(negedge clk);
      rst_n = 1'b1;
      check_sweep("restart_sweep");
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("midrst_no_stale", rf_we, 0);
      end
    end

    // Random traffic against a queue-based model, starting from a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = 1'b1; m_next = MLO; m_q.delete();
    e_we = 1'b0; e_err = 1'b0; e_addr = '0; e_data = '0;
    for (int n = 0; n < 1500; n++) begin
      bit acc, oor;
      check("rnd_we",   rf_we,   e_we);
      check("rnd_addr", rf_addr, e_addr);
      check("rnd_data", rf_data, e_data);
      check("rnd_err",  err_oor, e_err);
      check("rnd_rdy",  wr_rdy,  (m_q.size() < 2) ? 1 : 0);
      check("rnd_busy", busy,    m_busy);

      wr_en   = ($urandom_range(0, 3) != 0);
      wr_addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      clr     = ($urandom_range(0, 31) == 0);

      acc = wr_en && (m_q.size() < 2);
      oor = (int'(wr_addr) < MLO) || (int'(wr_addr) > MHI);
      if (m_busy) begin
        e_we = 1'b1; e_addr = 4'(m_next); e_data = 8'hA5;
        if (m_next == MHI) begin
          m_busy = 1'b0; m_next = MLO;
        end else begin
          m_next++;
        end
      end else if (clr) begin
        m_busy = 1'b1; e_we = 1'b0;
      end else if (m_q.size() > 0) begin
        {e_addr, e_data} = m_q.pop_front();
        e_we = 1'b1;
      end else begin
        e_we = 1'b0;
      end
      e_err = acc && oor;
      if (acc && !oor) m_q.push_back({wr_addr, wr_data});
      @(negedge clk);
    end
    wr_en = 1'b0; clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
